// File: rtl/gmii_auth_feeder.sv
// GMII receive-side front end: strips preamble/SFD and FCS from armed frames and
// streams the payload bytes through a small FIFO to the authentication core.
module gmii_auth_feeder #(
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  gmii_d,
    input  logic        gmii_dv,
    input  logic        gmii_er,
    input  logic        arm,
    output logic [7:0]  m_tdata,
    output logic        m_tvalid,
    output logic        m_tlast,
    input  logic        m_tready,
    output logic [15:0] frame_cnt,
    output logic [7:0]  runt_cnt,
    output logic [7:0]  err_cnt,
    output logic        ovf,
    output logic        busy
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_SOF,
        PREAMBLE,
        PAYLOAD,
        DROP
    } state_t;

    state_t          state_reg;
    logic [4:0][7:0] line_reg;
    logic [4:0][7:0] line_next;
    logic [2:0]      line_cnt_reg;
    logic            line_full;
    logic [15:0]     frame_cnt_reg;
    logic [7:0]      runt_cnt_reg;
    logic [7:0]      err_cnt_reg;
    logic            ovf_reg;

    logic            shift_en;
    logic            push_en;
    logic            push_last;
    logic [7:0]      push_data;

    logic [8:0]      mem [FIFO_DEPTH];
    logic [AW:0]     wr_ptr_reg;
    logic [AW:0]     rd_ptr_reg;
    logic            fifo_empty;
    logic            fifo_full;
    logic            pop;
    logic            wr_ok;
    logic [8:0]      head;

    assign line_full = (line_cnt_reg == 3'd5);

    // Delay line: index 0 is the newest byte, index 4 the oldest once five are held.
    generate
        for (genvar gi = 0; gi < 5; gi++) begin : g_line
            if (gi == 0) begin : g_head
                assign line_next[gi] = gmii_d;
            end else begin : g_tail
                assign line_next[gi] = line_reg[gi-1];
            end
        end
    endgenerate

    always_comb begin
        shift_en  = 1'b0;
        push_en   = 1'b0;
        push_last = 1'b0;
        push_data = line_reg[4];
        if (state_reg == PAYLOAD) begin
            if (gmii_dv && !gmii_er) begin
                shift_en = 1'b1;
                push_en  = line_full;
            end else begin
                // Frame end or error: the byte five behind closes the frame, rest is FCS
                push_en   = line_full;
                push_last = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (shift_en) begin
            line_reg <= line_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            line_cnt_reg  <= 3'd0;
            frame_cnt_reg <= 16'd0;
            runt_cnt_reg  <= 8'd0;
            err_cnt_reg   <= 8'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (arm && !gmii_dv) begin
                        state_reg <= WAIT_SOF;
                    end
                end
                WAIT_SOF: begin
                    if (!arm) begin
                        state_reg <= IDLE;
                    end else if (gmii_dv) begin
                        if (gmii_d == 8'h55 && !gmii_er) begin
                            state_reg <= PREAMBLE;
                        end else begin
                            state_reg <= DROP;
                        end
                    end
                end
                PREAMBLE: begin
                    if (!gmii_dv) begin
                        state_reg <= WAIT_SOF;
                    end else if (gmii_er) begin
                        state_reg <= DROP;
                    end else if (gmii_d == 8'hD5) begin
                        state_reg    <= PAYLOAD;
                        line_cnt_reg <= 3'd0;
                    end else if (gmii_d != 8'h55) begin
                        state_reg <= DROP;
                    end
                end
                PAYLOAD: begin
                    if (!gmii_dv) begin
                        if (line_full) begin
                            frame_cnt_reg <= frame_cnt_reg + 16'd1;
                        end else if (runt_cnt_reg != 8'hFF) begin
                            runt_cnt_reg <= runt_cnt_reg + 8'd1;
                        end
                        line_cnt_reg <= 3'd0;
                        state_reg    <= arm ? WAIT_SOF : IDLE;
                    end else if (gmii_er) begin
                        if (err_cnt_reg != 8'hFF) begin
                            err_cnt_reg <= err_cnt_reg + 8'd1;
                        end
                        line_cnt_reg <= 3'd0;
                        state_reg    <= DROP;
                    end else if (!line_full) begin
                        line_cnt_reg <= line_cnt_reg + 3'd1;
                    end
                end
                DROP: begin
                    if (!gmii_dv) begin
                        state_reg <= arm ? WAIT_SOF : IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
    assign fifo_full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                        (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign pop        = m_tvalid && m_tready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign wr_ok      = push_en && (!fifo_full || pop);

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr_reg[AW-1:0]] <= {push_last, push_data};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            ovf_reg    <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
            end
            if (push_en && fifo_full && !pop) begin
                ovf_reg <= 1'b1;
            end
        end
    end

    assign head      = mem[rd_ptr_reg[AW-1:0]];
    assign m_tvalid  = !fifo_empty;
    assign m_tdata   = m_tvalid ? head[7:0] : 8'h00;
    assign m_tlast   = m_tvalid && head[8];

    assign frame_cnt = frame_cnt_reg;
    assign runt_cnt  = runt_cnt_reg;
    assign err_cnt   = err_cnt_reg;
    assign ovf       = ovf_reg;
    assign busy      = (state_reg != IDLE) && (state_reg != WAIT_SOF);

endmodule

// File: doc/gmii_auth_feeder.md
GMII_AUTH_FEEDER -- requirements
Module: gmii_auth_feeder

Interface
REQ-001 SHALL have ports: clk in 1, GMII byte clock (gmii_tx_clk or gmii_rx_clk), sole clock; reset in 1, synchronous, active-high.
REQ-002 SHALL have GMII inputs: gmii_d in 8, byte; gmii_dv in 1, data valid; gmii_er in 1, error.
REQ-003 SHALL have control input arm in 1; level; frames accepted only while high.
REQ-004 SHALL have stream outputs m_tdata out 8, m_tvalid out 1, m_tlast out 1, and input m_tready in 1, feeding the authentication core's ss_* port.
REQ-005 SHALL have status outputs: frame_cnt out 16, frames delivered; runt_cnt out 8; err_cnt out 8; ovf out 1, sticky FIFO overflow; busy out 1, high outside IDLE/WAIT_SOF.
REQ-006 SHALL have parameter FIFO_DEPTH, default 16, power of two, output FIFO entries of {last,data}.

Function
REQ-007 SHALL implement FSM: IDLE, WAIT_SOF, PREAMBLE, PAYLOAD, DROP.
REQ-008 IDLE: if arm=1 and gmii_dv=0 -> WAIT_SOF; if gmii_dv=1 -> stay, ignoring the frame (no mid-frame lock-on).
REQ-009 WAIT_SOF: arm=0 -> IDLE; gmii_dv=1 and gmii_d=0x55 -> PREAMBLE; gmii_dv=1 with any other byte -> DROP.
REQ-010 PREAMBLE: 0x55 -> stay; 0xD5 -> PAYLOAD (SFD not forwarded); other byte, gmii_er=1, or gmii_dv=0 -> DROP (dv=0 goes straight to WAIT_SOF).
REQ-011 PAYLOAD: each dv byte enters 5-byte delay line; when line already holds 5 bytes, oldest byte pushed to FIFO with last=0.
REQ-012 PAYLOAD end (gmii_dv 1->0): line count=5 -> push oldest with last=1, discard remaining 4 bytes (FCS), frame_cnt+1; count<5 -> push nothing, runt_cnt+1; both -> WAIT_SOF.
REQ-013 gmii_er=1 in PAYLOAD: line count=5 -> push oldest with last=1; err_cnt+1; clear line; -> DROP.
REQ-014 DROP: stay until gmii_dv=0, then -> WAIT_SOF (arm=1) or IDLE (arm=0).
REQ-015 arm falling mid-frame SHALL NOT abort the frame; return to IDLE at frame end.
REQ-016 Push latency: payload byte k (0-based after SFD) reaches FIFO at cycle of byte k+5 acceptance plus 1; m_tvalid asserts cycle after first push when FIFO empty.
REQ-017 Stream: m_tvalid=~fifo_empty; entry popped when m_tvalid&m_tready; m_tdata/m_tlast SHALL hold stable while m_tvalid&~m_tready.
REQ-018 Simultaneous push and pop with FIFO full SHALL succeed (no overflow); pointers wrap modulo FIFO_DEPTH.
REQ-019 Push with FIFO full and no pop: byte dropped, ovf set, remaining frame still processed; a dropped last=1 entry is lost (not re-inserted).
REQ-020 frame_cnt wraps 0xFFFF->0x0000; runt_cnt, err_cnt saturate at 0xFF.
REQ-021 gmii_d SHALL be ignored whenever gmii_dv=0.

Reset
REQ-022 reset=1 at posedge clk: FSM->IDLE, FIFO and delay line emptied, m_tvalid=0, m_tlast=0, m_tdata=0x00, all counters 0, ovf=0, busy=0.
REQ-023 reset mid-frame: partial frame discarded; next accepted frame requires dv=0 before SOF (REQ-008).

Verification
REQ-024 arm=1, frame 7x0x55,0xD5, 64 bytes 0x00..0x3F, m_tready=1 -> 60 beats 0x00..0x3B, tlast only on 0x3B, frame_cnt=1.
REQ-025 Frame with 3 bytes after SFD -> no beats, runt_cnt=1, frame_cnt=0.
REQ-026 64-byte frame, gmii_er at byte 20 -> beats 0x00..0x0F, tlast on 0x0F, err_cnt=1, next frame delivered normally.
REQ-027 m_tready=0 whole 64-byte frame, FIFO_DEPTH=16 -> 16 entries 0x00..0x0F retained, ovf=1; after m_tready=1, exactly 16 beats, none with tlast.
REQ-028 arm=0 during frame start -> no beats; arm raised mid-frame -> that frame ignored, following frame delivered; reset asserted at payload byte 30 -> m_tvalid=0 next cycle, counters 0.
